// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD text feeder.
//   feeder_state_e : sequencer state encoding
//   lcd_bus_t      : {rs, rw, data[7:0]} word presented to the LCD controller
//   char_index()   : maps a transaction index to the buffer slot it sends
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StIssue,
    StWaitAck,
    StGap,
    StNext
  } feeder_state_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_bus_t;

  localparam int unsigned NCHARS        = 32;
  localparam logic [7:0]  LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0]  LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0]  LCD_SPACE     = 8'h20;

  // Transaction 0 and 17 are DDRAM address commands; everything else is a character.
  localparam logic [5:0]  LINE1_T = 6'd0;
  localparam logic [5:0]  LINE2_T = 6'd17;
  localparam logic [5:0]  LAST_T  = 6'd33;

  // Slot sent by transaction t: t-1 on line 1, t-2 on line 2 (skipping the 0xC0 command).
  // The result for the command slots is don't-care.
  function automatic logic [4:0] char_index(input logic [5:0] t);
    logic [5:0] idx;
    idx = (t <= 6'd16) ? (t - 6'd1) : (t - 6'd2);
    return idx[4:0];
  endfunction

endpackage

// File: rtl/lcd_text_buf.sv
// lcd_text_buf: 32 x 8 character buffer for the two display lines.
//   clk, rst_n : clock, synchronous active-low reset (buffer fills with spaces)
//   wr_en      : host write strobe; wr_char is stored at wr_addr
//   wr_addr    : write slot 0..31
//   wr_char    : character code to store
//   rd_addr    : asynchronous read slot
//   rd_char    : character stored at rd_addr
module lcd_text_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char
);

  logic [7:0] mem_q [NCHARS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCHARS); i++) begin
        mem_q[i] <= LCD_SPACE;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_char;
    end
  end

  assign rd_char = mem_q[rd_addr];

endmodule

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: streams a 2x16 text buffer to an HD44780-style controller.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en       : host buffer write strobe (accepted in every state)
//   wr_addr     : character slot 0..31 (0-15 line 1, 16-31 line 2)
//   wr_char     : character code
//   refresh     : one-cycle redraw request; queued as pending while a redraw runs
//   lcd_busy    : controller busy flag
//   lcd_enable  : one-cycle transfer request to the controller
//   lcd_bus     : registered {rs, rw, data}; held from one issue to the next
//   feeder_busy : high while a redraw is in progress
//   done        : one-cycle pulse when a redraw completes
//   ack_err     : sticky, set when an issue was not acknowledged in time
module lcd_text_feeder
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 45,
  parameter int unsigned GAP_CYCLES  = 2300,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       feeder_busy,
  output logic       done,
  output logic       ack_err
);

  // The controller needs at least 50 us of quiet after a transfer; never go below that.
  localparam int unsigned GapFloor = 50 * CLK_FREQ;
  localparam int unsigned GapLen   = (GAP_CYCLES > GapFloor) ? GAP_CYCLES : GapFloor;
  localparam int unsigned GapW     = $clog2(GapLen + 1);
  localparam int unsigned ToW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapLen - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(ACK_TIMEOUT - 1);

  feeder_state_e   state_q, state_d;
  logic [5:0]      t_q, t_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            pending_q, pending_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  lcd_bus_t        bus_q, bus_d;
  lcd_bus_t        issue_word;
  logic [7:0]      rd_char;

  lcd_text_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .rd_addr (char_index(t_q)),
    .rd_char (rd_char)
  );

  // The buffer is read at issue time, so late writes to unsent slots still make it out.
  always_comb begin
    issue_word = '{rs: 1'b1, rw: 1'b0, data: rd_char};
    if (t_q == LINE1_T) begin
      issue_word = '{rs: 1'b0, rw: 1'b0, data: LCD_CMD_LINE1};
    end else if (t_q == LINE2_T) begin
      issue_word = '{rs: 1'b0, rw: 1'b0, data: LCD_CMD_LINE2};
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    gap_d     = gap_q;
    to_d      = to_q;
    pending_d = pending_q | refresh;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    bus_d     = bus_q;

    unique case (state_q)
      StIdle: begin
        if (refresh || pending_q) begin
          pending_d = 1'b0;
          t_d       = '0;
          busy_d    = 1'b1;
          state_d   = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (!lcd_busy) begin
          bus_d   = issue_word;
          state_d = StIssue;
        end
      end
      StIssue: begin
        to_d    = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (lcd_busy) begin
          gap_d   = '0;
          state_d = StGap;
        end else if (to_q >= ToLast) begin
          // Retry the same transaction; bus_q is reloaded with the same word.
          err_d   = 1'b1;
          state_d = StWaitRdy;
        end else if (to_q != '1) begin
          to_d = to_q + ToW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StNext;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StNext: begin
        if (t_q == LAST_T) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          t_d     = t_q + 6'd1;
          state_d = StWaitRdy;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      t_q       <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bus_q     <= bus_d;
    end
  end

  assign lcd_enable  = (state_q == StIssue);
  assign lcd_bus     = bus_q;
  assign feeder_busy = busy_q;
  assign done        = done_q;
  assign ack_err     = err_q;

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Self-checking bench for lcd_text_feeder with a one-cycle-busy controller model.
module tb_lcd_text_feeder;

  localparam int unsigned Freq  = 1;
  localparam int unsigned Gap   = 60;
  localparam int unsigned Tmo   = 16;
  localparam int          Space = Gap + 4;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, refresh;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       lcd_busy, lcd_enable, feeder_busy, done, ack_err;
  logic [9:0] lcd_bus;

  logic busy_force = 1'b0;
  logic busy_pulse = 1'b0;
  logic ack_on     = 1'b1;

  int         tot = 0, bad = 0;
  int         cyc = 0;
  int         done_cnt = 0, viol = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] ref_buf [32];
  logic [9:0] exp_q [$];
  logic [9:0] en_bus [$];
  int         en_cyc [$];

  lcd_text_feeder #(
    .CLK_FREQ    (Freq),
    .GAP_CYCLES  (Gap),
    .ACK_TIMEOUT (Tmo)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .refresh     (refresh),
    .lcd_busy    (lcd_busy),
    .lcd_enable  (lcd_enable),
    .lcd_bus     (lcd_bus),
    .feeder_busy (feeder_busy),
    .done        (done),
    .ack_err     (ack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy for one cycle after an accepted enable.
  always @(posedge clk) busy_pulse <= lcd_enable & ack_on;
  assign lcd_busy = busy_force | busy_pulse;

  always @(negedge clk) begin
    if (lcd_enable) begin
      en_bus.push_back(lcd_bus);
      en_cyc.push_back(cyc);
      if (busy_prev) viol <= viol + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    busy_prev <= lcd_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
  endtask

  task automatic write_char(input int a, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_char = ch;
    step();
    wr_en   = 1'b0;
    ref_buf[a] = ch;
  endtask

  // Expected redraw: line-1 command, 16 chars, line-2 command, 16 chars.
  task automatic push_redraw();
    exp_q.push_back(10'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, ref_buf[i]});
    exp_q.push_back(10'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({2'b10, ref_buf[i]});
  endtask

  task automatic clear_log();
    en_bus.delete();
    en_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_enables(input int n, input int budget, input string tag);
    int k = 0;
    while (en_bus.size() < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_enable_wait"}, 32'(en_bus.size() >= n), 32'd1);
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done_wait"}, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, en_bus.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < en_bus.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), en_bus[i], exp_q[i]);
    end
  endtask

  initial begin
    int c, d0, e, i0;
    logic [7:0] old0;
    logic [7:0] hello [5];

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; refresh = 1'b0;
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    repeat (3) step();
    check("rst_enable", lcd_enable, 0);
    check("rst_bus", lcd_bus, 0);
    check("rst_feeder_busy", feeder_busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    rst_n = 1'b1;
    step();

    // Controller initialising: busy held high, refresh arrives meanwhile.
    busy_force = 1'b1;
    repeat (10) step();
    pulse_refresh();
    repeat (490) step();
    check("init_no_enable", en_bus.size(), 0);
    check("init_feeder_busy", feeder_busy, 1);
    c = cyc;
    busy_force = 1'b0;
    wait_enables(1, 10, "init");
    check("init_first_cycle", en_cyc[0], c + 1);
    check("init_first_bus", en_bus[0], 10'h080);
    wait_dones(1, 3000, "init");
    step();
    push_redraw();
    compare_log("init_seq");
    check("init_idle", feeder_busy, 0);

    // HELLO plus random characters elsewhere.
    clear_log();
    d0 = done_cnt;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) write_char(i, hello[i]);
    for (int i = 0; i < 8; i++) write_char($urandom_range(31, 5), 8'($urandom_range(126, 33)));
    pulse_refresh();
    wait_enables(5, 400, "hello");
    check("hello_feeder_busy", feeder_busy, 1);
    wait_dones(d0 + 1, 3000, "hello");
    repeat (20) step();
    push_redraw();
    compare_log("hello_seq");
    check("hello_H", en_bus[1], 10'h248);
    for (int i = 0; i < 33; i++) check($sformatf("spacing[%0d]", i), en_cyc[i+1] - en_cyc[i], Space);
    check("hello_one_done", done_cnt - d0, 1);

    // Writes and two refreshes during a redraw.
    clear_log();
    d0 = done_cnt;
    pulse_refresh();
    wait_enables(3, 400, "mid");
    old0 = ref_buf[0];
    write_char(0, old0 ^ 8'h01);
    write_char(20, 8'($urandom_range(126, 33)));
    pulse_refresh();
    repeat (100) step();
    pulse_refresh();
    push_redraw();
    exp_q[1] = {2'b10, old0};
    push_redraw();
    wait_dones(d0 + 2, 6000, "mid");
    repeat (200) step();
    compare_log("mid_seq");
    check("mid_restart_gap", en_cyc[34] - en_cyc[33], Space + 1);
    check("mid_two_dones", done_cnt - d0, 2);
    check("mid_idle", feeder_busy, 0);

    // Refresh arriving exactly in the final NEXT cycle.
    clear_log();
    d0 = done_cnt;
    pulse_refresh();
    wait_enables(34, 3000, "last");
    e = en_cyc[33];
    while (cyc < e + Gap + 2) step();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    check("last_done_pulse", done, 1);
    wait_dones(d0 + 2, 6000, "last");
    repeat (200) step();
    push_redraw();
    push_redraw();
    compare_log("last_seq");
    check("last_restart_gap", en_cyc[34] - e, Space + 1);

    // First issue never acknowledged.
    clear_log();
    d0 = done_cnt;
    ack_on = 1'b0;
    pulse_refresh();
    wait_enables(1, 50, "tmo");
    i0 = en_cyc[0];
    ack_on = 1'b1;
    while (cyc < i0 + 16) step();
    check("tmo_err_early", ack_err, 0);
    step();
    check("tmo_err_set", ack_err, 1);
    wait_dones(d0 + 1, 3000, "tmo");
    repeat (20) step();
    exp_q.push_back(10'h080);
    push_redraw();
    compare_log("tmo_seq");
    check("tmo_reissue_cycle", en_cyc[1] - i0, 18);
    check("tmo_err_sticky", ack_err, 1);

    // Reset in the middle of a redraw.
    clear_log();
    pulse_refresh();
    wait_enables(11, 1000, "rst");
    rst_n = 1'b0;
    step();
    check("mid_rst_enable", lcd_enable, 0);
    check("mid_rst_bus", lcd_bus, 0);
    check("mid_rst_feeder_busy", feeder_busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ack_err", ack_err, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    clear_log();
    d0 = done_cnt;
    pulse_refresh();
    wait_dones(d0 + 1, 3000, "post_rst");
    repeat (20) step();
    push_redraw();
    compare_log("post_rst_seq");

    check("busy_rule", viol, 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
